// File: rtl/ej32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ej32_pkg
//  Description : Shared types and constants for the eJ32 instruction fetch
//                path: fetch FSM state encoding and default queue depth.
//  Revision    : 1.0  initial release
// ============================================================================
package ej32_pkg;

    // Default prefetch queue depth in bytes (power of two, >= 2).
    localparam int FETCH_DEPTH = 4;

    // Fetch unit state machine.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,   // just out of reset, no fetching yet
        RUN   = 2'd1,   // normal prefetch
        DRAIN = 2'd2    // dropping responses made stale by a redirect
    } fetch_st_t;

endpackage
`default_nettype wire

// File: rtl/ej32_bfifo.sv
`default_nettype none
// ============================================================================
//  Module      : ej32_bfifo
//  Description : DEPTH x 8 byte queue with push, pop, flush and a
//                combinational head read. No overflow protection: the owner
//                guarantees a push never lands on a full queue.
//  Ports       : clk, rst (async active-low)
//                flush       empty the queue (wins over push/pop)
//                push, din   write din at the tail
//                pop         advance the head
//                head        byte at the head (undefined when cnt==0)
//                cnt         number of bytes held
//  Revision    : 1.0  initial release
// ============================================================================
module ej32_bfifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  logic [7:0]    din,
    input  logic          pop,
    output logic [7:0]    head,
    output logic [CW-1:0] cnt
);

    localparam int PW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [PW-1:0] r_wp;
    logic [PW-1:0] r_rp;
    logic [CW-1:0] r_cnt;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else if (flush) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (push) r_wp <= r_wp + PW'(1);
            if (pop)  r_rp <= r_rp + PW'(1);
            r_cnt <= r_cnt + CW'(push) - CW'(pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by r_cnt.
    always_ff @(posedge clk) begin
        if (push && !flush) r_mem[r_wp] <= din;
    end

    assign head = r_mem[r_rp];
    assign cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/ej32_fetch.sv
`default_nettype none
// ============================================================================
//  Module      : ej32_fetch
//  Description : eJ32 instruction fetch unit. Prefetches bytecode into a
//                small byte queue, presents the head byte and its address to
//                the decoder, and redirects on BR loads while discarding
//                responses to requests issued before the redirect.
//  Ports       : clk, rst (async active-low)
//                p_inc              decoder consumed the head byte
//                br_ld, br_pc       redirect strobe / target
//                data, pc, vld      head byte, its address, valid
//                mem_req, mem_addr  registered read request
//                mem_gnt            request accepted this cycle
//                mem_rvld, mem_dat  in-order read data return
//  Revision    : 1.0  initial release
// ============================================================================
module ej32_fetch
    import ej32_pkg::*;
#(
    parameter int AW    = 17,
    parameter int DEPTH = FETCH_DEPTH
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p_inc,
    input  logic          br_ld,
    input  logic [AW-1:0] br_pc,
    output logic [7:0]    data,
    output logic [AW-1:0] pc,
    output logic          vld,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_gnt,
    input  logic          mem_rvld,
    input  logic [7:0]    mem_dat
);

    localparam int            CW      = $clog2(DEPTH + 1);
    localparam logic [CW:0]   c_depth = (CW + 1)'(DEPTH);

    fetch_st_t     r_st, w_st_n;
    logic [AW-1:0] r_fa, w_fa_n;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_mem_addr;
    logic          r_mem_req, w_req_n;
    logic [CW-1:0] r_out, w_out_n;
    logic [CW-1:0] r_stale, w_stale_n;
    logic [CW-1:0] w_cnt, w_cnt_n;
    logic          w_acc, w_rvld, w_push, w_pop;
    logic [7:0]    w_head;

    assign w_acc  = r_mem_req & mem_gnt;
    // A response only counts against a request we actually have in flight;
    // anything else (e.g. left over from before a reset) is ignored.
    assign w_rvld = mem_rvld & (r_st != IDLE) & (r_out != '0);
    assign vld    = (r_st == RUN) & (w_cnt != '0);
    assign w_push = w_rvld & (r_st == RUN) & ~br_ld;
    assign w_pop  = p_inc & vld & ~br_ld;

    assign w_out_n = r_out + CW'(w_acc) - CW'(w_rvld);
    assign w_fa_n  = br_ld ? br_pc : r_fa + AW'(w_acc);
    assign w_cnt_n = br_ld ? '0 : w_cnt + CW'(w_push) - CW'(w_pop);

    // Credit rule: occupancy plus in-flight requests never exceeds DEPTH,
    // so every response has a free slot. The first RUN cycle after IDLE
    // issues nothing, giving one cycle of fetch latency after reset.
    assign w_req_n = (r_st != IDLE) && (w_st_n == RUN) &&
                     (({1'b0, w_cnt_n} + {1'b0, w_out_n}) < c_depth);

    always_comb begin
        w_st_n    = r_st;
        w_stale_n = r_stale;
        if (br_ld) begin
            // Everything still in flight after this edge is stale.
            w_stale_n = w_out_n;
            w_st_n    = (w_out_n != '0) ? DRAIN : RUN;
        end else begin
            case (r_st)
                IDLE:  w_st_n = RUN;
                RUN:   w_st_n = RUN;
                DRAIN: begin
                    if (w_rvld) begin
                        w_stale_n = r_stale - CW'(1);
                        if (r_stale == CW'(1)) w_st_n = RUN;
                    end
                end
                default: w_st_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st       <= IDLE;
            r_fa       <= '0;
            r_pc       <= '0;
            r_out      <= '0;
            r_stale    <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_st       <= w_st_n;
            r_fa       <= w_fa_n;
            r_pc       <= br_ld ? br_pc : r_pc + AW'(w_pop);
            r_out      <= w_out_n;
            r_stale    <= w_stale_n;
            r_mem_req  <= w_req_n;
            r_mem_addr <= w_fa_n;
        end
    end

    ej32_bfifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_bfifo (
        .clk   (clk),
        .rst   (rst),
        .flush (br_ld),
        .push  (w_push),
        .din   (mem_dat),
        .pop   (w_pop),
        .head  (w_head),
        .cnt   (w_cnt)
    );

    assign data     = vld ? w_head : 8'h00;
    assign pc       = r_pc;
    assign mem_req  = r_mem_req;
    assign mem_addr = r_mem_addr;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        w_push |-> (w_cnt != CW'(DEPTH)));

endmodule
`default_nettype wire
